// File: rtl/evt_counter_bank_if.sv
// Control/status bundle for evt_counter_bank: events, clears and periods in,
// packed counts and terminal-event pulses out.
interface evt_counter_bank_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16
);
  logic                    en_in;
  logic [NUM_CH-1:0]       evt_in;
  logic [NUM_CH-1:0]       clear_in;
  logic [NUM_CH*WIDTH-1:0] period_in;
  logic [NUM_CH*WIDTH-1:0] count_out;
  logic [NUM_CH-1:0]       hit_max;
  logic                    all_hit_out;

  modport master (
    output en_in, evt_in, clear_in, period_in,
    input  count_out, hit_max, all_hit_out
  );

  modport slave (
    input  en_in, evt_in, clear_in, period_in,
    output count_out, hit_max, all_hit_out
  );
endinterface

// File: rtl/evt_counter_bank.sv
// Bank of NUM_CH programmable event counters with optional cascading of
// terminal events and wrap/saturate behaviour at the terminal count.
module evt_counter_bank #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 16,
  parameter int CHAIN    = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  evt_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]  cnt_p1   [NUM_CH];
  logic [WIDTH-1:0]  last_p0  [NUM_CH];
  logic [NUM_CH-1:0] evt_p0;
  logic [NUM_CH-1:0] term_p0;
  logic [NUM_CH-1:0] carry_p0;
  logic [NUM_CH-1:0] hit_p1;
  logic              all_hit_p1;

  // Terminal count value P-1, with a zero period treated as period 1.
  function automatic logic [WIDTH-1:0] last_val(input logic [WIDTH-1:0] period);
    logic [WIDTH-1:0] r;
    if (period == '0) r = '0;
    else              r = period - ONE;
    return r;
  endfunction

  // Count update for one channel once clear has been ruled out.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cnt,
    input logic [WIDTH-1:0] last,
    input logic             term,
    input logic             evt
  );
    logic [WIDTH-1:0] r;
    r = cnt;
    if (term) begin
      if (SATURATE != 0) r = last;
      else               r = '0;
    end else if (evt) begin
      r = cnt + ONE;
    end
    return r;
  endfunction

  // ---- stage p0: effective events, terminal detect, same-cycle carry ripple
  always_comb begin
    logic carry;
    logic raw;
    evt_p0   = '0;
    term_p0  = '0;
    carry_p0 = '0;
    carry    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      last_p0[i] = last_val(bus.period_in[i*WIDTH +: WIDTH]);
      raw = bus.evt_in[i];
      if ((CHAIN != 0) && (i > 0)) evt_p0[i] = bus.en_in & carry;
      else                         evt_p0[i] = bus.en_in & raw;
      term_p0[i] = evt_p0[i] & (cnt_p1[i] >= last_p0[i]);
      // A cleared channel swallows its own terminal event for the next stage.
      carry_p0[i] = term_p0[i] & ~bus.clear_in[i];
      carry       = carry_p0[i];
    end
  end

  // ---- stage p1: counter state and registered terminal pulses
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) cnt_p1[i] <= '0;
      hit_p1     <= '0;
      all_hit_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.clear_in[i]) cnt_p1[i] <= '0;
        else cnt_p1[i] <= next_count(cnt_p1[i], last_p0[i], term_p0[i], evt_p0[i]);
      end
      hit_p1     <= carry_p0;
      all_hit_p1 <= &carry_p0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.count_out[g*WIDTH +: WIDTH] = cnt_p1[g];
  end

  assign bus.hit_max     = hit_p1;
  assign bus.all_hit_out = all_hit_p1;

endmodule
